// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline (request side) and the stall/flush controller.
// Requests are level-sensitive with no ready/valid handshake: the controller answers in the same cycle.
interface pipe_hazard_ctrl_if #(
    parameter int NUM_STAGES = 6,
    parameter int NUM_REQ    = 4
);
    localparam int SRC_W = $clog2(NUM_REQ + 1);

    logic [NUM_REQ-1:0]    stallreq;
    logic                  exc_valid;
    logic [31:0]           exc_pc;
    logic                  clr_stat;
    logic                  flush;
    logic [31:0]           new_pc;
    logic [NUM_STAGES-1:0] stall;
    logic [SRC_W-1:0]      stall_src;
    logic                  stall_timeout;
    logic [31:0]           stall_cnt;

    modport master (
        output stallreq, exc_valid, exc_pc, clr_stat,
        input  flush, new_pc, stall, stall_src, stall_timeout, stall_cnt
    );

    modport slave (
        input  stallreq, exc_valid, exc_pc, clr_stat,
        output flush, new_pc, stall, stall_src, stall_timeout, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: priority-encoded stall masks, multi-cycle flush hold,
// stall watchdog with sticky timeout and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES                              = 6,
    parameter int NUM_REQ                                 = 4,
    parameter logic [NUM_REQ*NUM_STAGES-1:0] REQ_MASKS    = 24'h04537D,
    parameter int FLUSH_CYCLES                            = 1,
    parameter int TIMEOUT                                 = 256
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam int SRC_W  = $clog2(NUM_REQ + 1);
    localparam int HOLD_W = $clog2(FLUSH_CYCLES + 1);
    localparam int RUN_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(FLUSH_CYCLES - 1);
    localparam logic [RUN_W-1:0]  RUN_MAX     = RUN_W'(TIMEOUT);
    localparam logic [RUN_W-1:0]  RUN_PRE     = RUN_W'(TIMEOUT - 1);
    localparam logic [SRC_W-1:0]  NO_REQ      = SRC_W'(NUM_REQ);

    logic [HOLD_W-1:0]     hold_cnt;
    logic [31:0]           held_pc;
    logic [RUN_W-1:0]      run_cnt;
    logic [SRC_W-1:0]      win;
    logic [NUM_STAGES-1:0] win_mask;
    logic                  hold_active;
    logic                  stalled;
    logic                  timeout_hit;

    // Lowest-index request wins; scanning downwards leaves the smallest set index.
    always_comb begin
        win = NO_REQ;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.stallreq[i]) win = SRC_W'(i);
        end
    end

    always_comb begin
        win_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == SRC_W'(i)) win_mask = REQ_MASKS[i*NUM_STAGES +: NUM_STAGES];
        end
    end

    assign hold_active = (hold_cnt != '0);

    assign bus.flush  = !rst && (bus.exc_valid || hold_active);
    assign bus.new_pc = rst           ? 32'd0      :
                        bus.exc_valid ? bus.exc_pc :
                        hold_active   ? held_pc    : 32'd0;

    // stall_src still reports the winner while flush masks the stall vector.
    assign bus.stall     = (rst || bus.flush) ? '0 : win_mask;
    assign bus.stall_src = rst ? NO_REQ : win;

    assign stalled     = |bus.stall;
    assign timeout_hit = (TIMEOUT != 0) && stalled && (run_cnt == RUN_PRE);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt          <= '0;
            held_pc           <= 32'd0;
            run_cnt           <= '0;
            bus.stall_timeout <= 1'b0;
            bus.stall_cnt     <= 32'd0;
        end else begin
            // The newest exception restarts the hold with its own PC.
            if (bus.exc_valid) begin
                held_pc  <= bus.exc_pc;
                hold_cnt <= HOLD_RELOAD;
            end else if (hold_active) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end

            if (stalled) begin
                if (run_cnt != RUN_MAX) run_cnt <= run_cnt + RUN_W'(1);
            end else begin
                run_cnt <= '0;
            end

            if (bus.clr_stat) begin
                bus.stall_timeout <= 1'b0;
                bus.stall_cnt     <= 32'd0;
            end else begin
                if (timeout_hit) bus.stall_timeout <= 1'b1;
                if (stalled && (bus.stall_cnt != 32'hFFFF_FFFF))
                    bus.stall_cnt <= bus.stall_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations driven in lockstep and compared every
// cycle against a cycle-indexed behavioural model, plus the directed scenarios.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] stallreq = '0;
  logic exc_valid = 1'b0;
  logic [31:0] exc_pc = '0;
  logic clr_stat = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NUM_STAGES(6), .NUM_REQ(4)) if_a ();
  pipe_hazard_ctrl_if #(.NUM_STAGES(6), .NUM_REQ(4)) if_b ();

  assign if_a.stallreq = stallreq;
  assign if_a.exc_valid = exc_valid;
  assign if_a.exc_pc = exc_pc;
  assign if_a.clr_stat = clr_stat;
  assign if_b.stallreq = stallreq;
  assign if_b.exc_valid = exc_valid;
  assign if_b.exc_pc = exc_pc;
  assign if_b.clr_stat = clr_stat;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(4)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  pipe_hazard_ctrl #(.FLUSH_CYCLES(4), .TIMEOUT(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: flush windows are tracked as absolute cycle ranges.
  int fc_p[2] = '{3, 4};
  int to_p[2] = '{4, 0};
  logic [5:0] masks[4] = '{6'b111101, 6'b001101, 6'b000101, 6'b000001};
  longint cyc = 0;
  longint flush_until[2] = '{-1, -1};
  logic [31:0] m_pc[2];
  int run[2] = '{0, 0};
  logic m_to[2] = '{0, 0};
  longint m_cnt[2] = '{0, 0};

  task automatic model_inst(input int k, input logic fl, input logic [31:0] np,
                            input logic [5:0] st, input logic [2:0] src,
                            input logic to, input logic [31:0] cnt);
    logic fl_e;
    logic [31:0] pc_e;
    logic [5:0] st_e;
    int w;
    string p;
    p = (k == 0) ? "a" : "b";
    w = 4;
    for (int i = 3; i >= 0; i--) if (stallreq[i]) w = i;
    fl_e = !rst && (exc_valid || cyc <= flush_until[k]);
    pc_e = rst ? 32'd0 : exc_valid ? exc_pc : (cyc <= flush_until[k]) ? m_pc[k] : 32'd0;
    st_e = (rst || fl_e || w == 4) ? 6'd0 : masks[w];
    check({p, ".flush"}, 64'(fl), 64'(fl_e));
    check({p, ".new_pc"}, 64'(np), 64'(pc_e));
    check({p, ".stall"}, 64'(st), 64'(st_e));
    check({p, ".stall_src"}, 64'(src), rst ? 64'd4 : 64'(w));
    check({p, ".stall_timeout"}, 64'(to), 64'(m_to[k]));
    check({p, ".stall_cnt"}, 64'(cnt), 64'(m_cnt[k]));
    if (rst) begin
      flush_until[k] = -1;
      run[k] = 0;
      m_to[k] = 1'b0;
      m_cnt[k] = 0;
    end else begin
      if (exc_valid) begin
        flush_until[k] = cyc + fc_p[k] - 1;
        m_pc[k] = exc_pc;
      end
      if (st_e != 0) begin
        run[k]++;
        if (!clr_stat && to_p[k] > 0 && run[k] == to_p[k]) m_to[k] = 1'b1;
        if (!clr_stat && m_cnt[k] < 64'hFFFF_FFFF) m_cnt[k]++;
      end else begin
        run[k] = 0;
      end
      if (clr_stat) begin
        m_to[k] = 1'b0;
        m_cnt[k] = 0;
      end
    end
  endtask

  // One clock: apply inputs after the falling edge, check mid-cycle, model the rising edge.
  task automatic cycle(input logic r, input logic [3:0] sr, input logic ev,
                       input logic [31:0] pc, input logic cs);
    @(negedge clk);
    rst = r;
    stallreq = sr;
    exc_valid = ev;
    exc_pc = pc;
    clr_stat = cs;
    #1;
    model_inst(0, if_a.flush, if_a.new_pc, if_a.stall, if_a.stall_src, if_a.stall_timeout, if_a.stall_cnt);
    model_inst(1, if_b.flush, if_b.new_pc, if_b.stall, if_b.stall_src, if_b.stall_timeout, if_b.stall_cnt);
    cyc++;
  endtask

  initial begin
    // T1 reset with every request active
    cycle(1, 4'hF, 1, 32'h1234_5678, 0);
    cycle(1, 4'hF, 1, 32'h1234_5678, 0);
    check("t1.flush", 64'(if_a.flush), 64'd0);
    check("t1.src", 64'(if_a.stall_src), 64'd4);
    cycle(0, 4'h0, 0, 0, 0);
    check("t1.cnt", 64'(if_a.stall_cnt), 64'd0);

    // T2 priority
    cycle(0, 4'b1110, 0, 0, 0);
    check("t2.stall_1110", 64'(if_a.stall), 64'(6'b001101));
    check("t2.src_1110", 64'(if_a.stall_src), 64'd1);
    cycle(0, 4'b1000, 0, 0, 0);
    check("t2.stall_1000", 64'(if_a.stall), 64'(6'b000001));
    check("t2.src_1000", 64'(if_a.stall_src), 64'd3);
    cycle(0, 4'b0000, 0, 0, 0);
    check("t2.stall_0000", 64'(if_a.stall), 64'd0);
    check("t2.src_0000", 64'(if_a.stall_src), 64'd4);

    // T3 three-cycle flush hold on dut_a
    cycle(0, 4'b0001, 1, 32'hBFC0_0380, 0);
    check("t3.flush0", 64'(if_a.flush), 64'd1);
    for (int i = 1; i < 3; i++) begin
      cycle(0, 4'b0001, 0, 32'h0, 0);
      check("t3.flush_hold", 64'(if_a.flush), 64'd1);
      check("t3.pc_hold", 64'(if_a.new_pc), 64'hBFC0_0380);
      check("t3.stall_hold", 64'(if_a.stall), 64'd0);
    end
    cycle(0, 4'b0001, 0, 32'h0, 0);
    check("t3.flush_end", 64'(if_a.flush), 64'd0);
    check("t3.stall_end", 64'(if_a.stall), 64'(6'b111101));
    check("t3.pc_end", 64'(if_a.new_pc), 64'd0);
    cycle(0, 4'b0000, 0, 0, 0);
    cycle(0, 4'b0000, 0, 0, 0);

    // T4 re-exception in hold cycle 2
    cycle(0, 4'b0000, 1, 32'hBFC0_0380, 0);
    cycle(0, 4'b0000, 1, 32'h8000_0000, 0);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 4'b0000, 0, 32'h0, 0);
      check("t4.flush_hold", 64'(if_a.flush), 64'd1);
      check("t4.pc_hold", 64'(if_a.new_pc), 64'h8000_0000);
    end
    cycle(0, 4'b0000, 0, 32'h0, 0);
    check("t4.flush_end", 64'(if_a.flush), 64'd0);
    cycle(0, 4'b0000, 0, 0, 0);
    cycle(0, 4'b0000, 0, 0, 0);

    // T5 watchdog on dut_a; dut_b has it disabled
    for (int i = 0; i < 4; i++) cycle(0, 4'b0100, 0, 0, 0);
    cycle(0, 4'b0000, 0, 0, 0);
    check("t5.timeout_a", 64'(if_a.stall_timeout), 64'd1);
    check("t5.timeout_b", 64'(if_b.stall_timeout), 64'd0);
    cycle(0, 4'b0000, 0, 0, 0);
    check("t5.sticky", 64'(if_a.stall_timeout), 64'd1);
    cycle(0, 4'b0000, 0, 0, 1);
    cycle(0, 4'b0000, 0, 0, 0);
    check("t5.cleared", 64'(if_a.stall_timeout), 64'd0);
    check("t5.cnt_cleared", 64'(if_a.stall_cnt), 64'd0);

    // T6 reset in hold cycle 2 of dut_b
    cycle(0, 4'b0000, 1, 32'hBFC0_0380, 0);
    cycle(0, 4'b0000, 0, 0, 0);
    cycle(1, 4'b0000, 0, 0, 0);
    check("t6.flush_rst", 64'(if_b.flush), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 4'b0000, 0, 0, 0);
      check("t6.no_residual", 64'(if_b.flush), 64'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(63) == 0), 4'($urandom_range(15)),
            ($urandom_range(7) == 0), $urandom, ($urandom_range(40) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
